mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the vector ASIP pipeline. It consumes the EX/MEM bundle (ALU result, store data, control bits, destination register) and runs loads and stores over a request/grant/read-valid data-memory bus with variable latency. While an access is outstanding it stalls upstream, then emits a registered MEM/WB bundle to the writeback stage. One instruction is in flight at a time.

## Interface
Parameters:
- N, 32, data and address width
- MAX_WAIT, 15, bus cycles allowed in REQ or WAIT before timeout abort (≥1)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, synchronous, active-low; one clock, synchronous active-low reset
- Valid_i  in  1  EX/MEM holds a valid instruction
- RD2_i  in  N  store data
- AluResult_i  in  N  memory address, or result for non-memory ops
- MemWE_i  in  1  store
- WBSelect_i  in  1  load (writeback from memory)
- RF_WE_i  in  1  register-file write enable
- A3_i  in  4  destination register
- Stall_o  out  1  upstream must hold EX/MEM
- MemReq_o  out  1  bus request
- MemWr_o  out  1  1 = write, 0 = read
- MemAddr_o  out  N  bus address
- MemWData_o  out  N  bus write data
- MemGnt_i  in  1  request accepted this cycle
- MemRValid_i  in  1  read data valid
- MemRData_i  in  N  read data
- Valid_o  out  1  MEM/WB bundle valid, 1-cycle pulse per instruction
- RF_WE_o  out  1  writeback enable
- A3_o  out  4  destination register
- AluResult_o  out  N  ALU result passthrough
- ReadData_o  out  N  loaded data
- WBSelect_o  out  1  writeback mux select
- Err_o  out  1  sticky bus-timeout flag

## Operation
- FSM states: IDLE, REQ, WAIT.
- Stall_o = (state != IDLE), a Moore output. Inputs are sampled only in IDLE with Valid_i=1.
- IDLE, Valid_i=1, MemWE_i=0, WBSelect_i=0: at the next edge, register the bundle to the outputs:
  - Valid_o=1, RF_WE_o=RF_WE_i, A3_o, AluResult_o
  - WBSelect_o=0, ReadData_o=0
  - Stay in IDLE.
- IDLE, Valid_i=1, MemWE_i|WBSelect_i: capture all inputs into holding registers and go to REQ. If both bits are set, the op is a store with captured RF_WE forced to 0.
- REQ:
  - MemReq_o=1; MemWr_o, MemAddr_o and MemWData_o driven from holding registers and stable until grant.
  - On MemGnt_i, a store emits the bundle at that edge (Valid_o=1, RF_WE_o=0, WBSelect_o=0) and goes to IDLE.
  - On MemGnt_i, a load goes to WAIT.
- WAIT:
  - MemReq_o=0.
  - On MemRValid_i, ReadData_o=MemRData_i, WBSelect_o=1, RF_WE_o=captured RF_WE, Valid_o=1; go to IDLE.
  - MemRValid_i is ignored outside WAIT.
- Timeout:
  - Counter clears on entering REQ and on the REQ→WAIT transition, and increments each cycle in REQ/WAIT.
  - When it reaches MAX_WAIT without progress, abort: Err_o←1 (sticky until reset), emit Valid_o=1 with RF_WE_o=0, go to IDLE.
- Bus address and data come from holding registers when state is REQ; MemReq_o is never 1 outside REQ.
- Bubbles: Valid_o=0 ⇒ RF_WE_o=0. AluResult_o, A3_o and ReadData_o hold their last value.

## Timing
- Reset (RST_N=0 at an edge): state IDLE, counter 0, all outputs 0, including Stall_o, MemReq_o and Err_o. Reset mid-access abandons the access; MemReq_o is 0 from the following cycle, with no MEM/WB emission.
- Non-memory op: 1-cycle latency, Stall_o stays 0, back-to-back throughput of 1 instruction per cycle.
- Store, grant in first REQ cycle: bundle valid 2 cycles after capture edge; Stall_o high 1 cycle.
- Load, grant in first REQ cycle and rvalid in first WAIT cycle: bundle valid 3 cycles after capture; Stall_o high 2 cycles.
- Each extra grant or read-valid wait cycle adds one cycle of latency and one cycle of Stall_o.
- Stall_o drops in the same cycle Valid_o rises. The instruction held in EX/MEM is sampled in that cycle (IDLE), so there is no gap between consecutive instructions.
- MemGnt_i and timeout on the same edge: grant wins.

## Test plan
- Non-mem op burst: 3 consecutive ALU ops (A3=1,2,3, AluResult=0x10,0x20,0x30) → Valid_o 3 consecutive cycles, RF_WE_o=1, matching A3_o/AluResult_o, Stall_o=0 throughout.
- Store to 0x100, data 0xDEADBEEF, MemGnt_i delayed 2 cycles → MemReq_o=1 for 3 cycles with stable addr/data, MemWr_o=1; Valid_o one pulse with RF_WE_o=0; Stall_o 3 cycles.
- Load from 0x40, grant immediately, MemRValid_i 4 cycles later with 0xCAFE0001 → ReadData_o=0xCAFE0001, WBSelect_o=1, RF_WE_o=1, A3_o preserved; next queued instruction accepted the same cycle.
- Timeout: load, MemGnt_i never asserted, MAX_WAIT=15 → abort after 15 REQ cycles; Valid_o pulse with RF_WE_o=0; Err_o=1 and held across later traffic until RST_N=0.
- Reset during WAIT → next cycle all outputs 0, state IDLE; a late MemRValid_i produces no Valid_o.
- MemWE_i=WBSelect_i=1, RF_WE_i=1 → bus write performed, RF_WE_o=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store stage with req/gnt/rvalid bus, stall and timeout abort
module mem_access_stage #(
    parameter int N        = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         Valid_i,
    input  logic [N-1:0] RD2_i,
    input  logic [N-1:0] AluResult_i,
    input  logic         MemWE_i,
    input  logic         WBSelect_i,
    input  logic         RF_WE_i,
    input  logic [3:0]   A3_i,
    output logic         Stall_o,
    output logic         MemReq_o,
    output logic         MemWr_o,
    output logic [N-1:0] MemAddr_o,
    output logic [N-1:0] MemWData_o,
    input  logic         MemGnt_i,
    input  logic         MemRValid_i,
    input  logic [N-1:0] MemRData_i,
    output logic         Valid_o,
    output logic         RF_WE_o,
    output logic [3:0]   A3_o,
    output logic [N-1:0] AluResult_o,
    output logic [N-1:0] ReadData_o,
    output logic         WBSelect_o,
    output logic         Err_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    localparam int CW = $clog2(MAX_WAIT + 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] addr_q, addr_d, wdata_q, wdata_d, alu_q, alu_d, rdata_q, rdata_d;
    logic [3:0] ha3_q, ha3_d, a3_q, a3_d;
    logic wr_q, wr_d, hrf_q, hrf_d, valid_q, valid_d, rf_we_q, rf_we_d;
    logic wbsel_q, wbsel_d, err_q, err_d, timeout;
    assign timeout    = cnt_q == CW'(MAX_WAIT - 1);
    assign Stall_o    = state_q != IDLE;
    assign MemReq_o   = state_q == REQ;
    assign MemWr_o    = MemReq_o & wr_q;
    assign MemAddr_o  = MemReq_o ? addr_q : '0;
    assign MemWData_o = MemReq_o ? wdata_q : '0;
    assign Valid_o     = valid_q;
    assign RF_WE_o     = rf_we_q;
    assign A3_o        = a3_q;
    assign AluResult_o = alu_q;
    assign ReadData_o  = rdata_q;
    assign WBSelect_o  = wbsel_q;
    assign Err_o       = err_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        hrf_d   = hrf_q;
        ha3_d   = ha3_q;
        valid_d = 1'b0;
        rf_we_d = 1'b0;
        a3_d    = a3_q;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        wbsel_d = wbsel_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (Valid_i) begin
                if (MemWE_i | WBSelect_i) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    addr_d  = AluResult_i;
                    wdata_d = RD2_i;
                    wr_d    = MemWE_i;
                    hrf_d   = RF_WE_i & ~MemWE_i;
                    ha3_d   = A3_i;
                end else begin
                    valid_d = 1'b1;
                    rf_we_d = RF_WE_i;
                    a3_d    = A3_i;
                    alu_d   = AluResult_i;
                    rdata_d = '0;
                    wbsel_d = 1'b0;
                end
            end
            REQ: if (MemGnt_i) begin
                if (wr_q) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    a3_d    = ha3_q;
                    alu_d   = addr_q;
                    rdata_d = '0;
                    wbsel_d = 1'b0;
                end else begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end else if (timeout) begin
                state_d = IDLE;
                valid_d = 1'b1;
                err_d   = 1'b1;
                a3_d    = ha3_q;
                alu_d   = addr_q;
                wbsel_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            WAIT: if (MemRValid_i) begin
                state_d = IDLE;
                valid_d = 1'b1;
                rf_we_d = hrf_q;
                a3_d    = ha3_q;
                alu_d   = addr_q;
                rdata_d = MemRData_i;
                wbsel_d = 1'b1;
            end else if (timeout) begin
                state_d = IDLE;
                valid_d = 1'b1;
                err_d   = 1'b1;
                a3_d    = ha3_q;
                alu_d   = addr_q;
                wbsel_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            hrf_q   <= 1'b0;
            ha3_q   <= '0;
            valid_q <= 1'b0;
            rf_we_q <= 1'b0;
            a3_q    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            wbsel_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            hrf_q   <= hrf_d;
            ha3_q   <= ha3_d;
            valid_q <= valid_d;
            rf_we_q <= rf_we_d;
            a3_q    <= a3_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            wbsel_q <= wbsel_d;
            err_q   <= err_d;
        end
    end
endmodule
